// File: rtl/run_det_pkg.sv
// Shared types and constants for the run-length detector controller.
// Holds the FSM state encoding, datapath widths and MODE codes.
package run_det_pkg;

  localparam int unsigned WORD_W  = 8;
  localparam int unsigned MAX_RUN = 8;
  localparam int unsigned N_MIN   = 2;
  localparam int unsigned CNT_W   = 8;

  localparam logic [1:0] MODE_ZERO = 2'b00;
  localparam logic [1:0] MODE_ONE  = 2'b01;
  localparam logic [1:0] MODE_ANY  = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StFin
  } state_e;

  // Clamp the requested run length into [N_MIN, MAX_RUN].
  function automatic logic [3:0] clamp_n(input logic [3:0] n);
    if (n < 4'(N_MIN)) begin
      return 4'(N_MIN);
    end else if (n > 4'(MAX_RUN)) begin
      return 4'(MAX_RUN);
    end
    return n;
  endfunction

  // Polarity filter: MODE[1] set accepts either polarity.
  function automatic logic mode_allows(input logic [1:0] mode, input logic bit_val);
    if (mode[1]) begin
      return 1'b1;
    end else if (mode == MODE_ONE) begin
      return bit_val;
    end
    return ~bit_val;
  endfunction

endpackage

// File: rtl/run_det_ctrl_if.sv
// Frame configuration, data handshake and status signals of run_det_ctrl.
// master drives configuration and data; slave is the controller.
interface run_det_ctrl_if;
  import run_det_pkg::*;

  logic              START;
  logic [3:0]        RUN_LEN;
  logic [1:0]        MODE;
  logic [3:0]        WORDS;
  logic [WORD_W-1:0] DIN;
  logic              DIN_VALID;
  logic              DIN_READY;
  logic              HIT;
  logic [CNT_W-1:0]  HIT_CNT;
  logic              BUSY;
  logic              DONE;

  modport master (
    output START, RUN_LEN, MODE, WORDS, DIN, DIN_VALID,
    input  DIN_READY, HIT, HIT_CNT, BUSY, DONE
  );

  modport slave (
    input  START, RUN_LEN, MODE, WORDS, DIN, DIN_VALID,
    output DIN_READY, HIT, HIT_CNT, BUSY, DONE
  );

endinterface

// File: rtl/run_detector.sv
// Tracks the current run (last bit, saturating length) across strobed bits and
// emits a registered HIT one cycle after a bit that completes a qualifying run.
module run_detector
  import run_det_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_bit,
  input  logic       i_strobe,
  input  logic       i_clear,
  input  logic [3:0] i_n,
  input  logic [1:0] i_mode,
  output logic       o_hit
);

  logic       r_last;
  logic [3:0] r_len;
  logic       r_hit;
  logic [3:0] w_len_next;
  logic       w_hit_next;

  // r_len == 0 marks "no bit seen yet in this frame".
  always_comb begin
    w_len_next = 4'd1;
    if ((r_len != 4'd0) && (i_bit == r_last)) begin
      w_len_next = (r_len < 4'(MAX_RUN)) ? (r_len + 4'd1) : r_len;
    end
    w_hit_next = (w_len_next >= i_n) && mode_allows(i_mode, i_bit);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_last <= 1'b0;
      r_len  <= 4'd0;
      r_hit  <= 1'b0;
    end else if (i_clear) begin
      r_last <= 1'b0;
      r_len  <= 4'd0;
      r_hit  <= 1'b0;
    end else if (i_strobe) begin
      r_last <= i_bit;
      r_len  <= w_len_next;
      r_hit  <= w_hit_next;
    end else begin
      r_hit  <= 1'b0;
    end
  end

  assign o_hit = r_hit;

endmodule

// File: rtl/run_det_ctrl.sv
// Frame controller: loads words, serializes them MSB first into run_detector,
// counts hits and signals frame completion.
module run_det_ctrl
  import run_det_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  run_det_ctrl_if.slave  ctrl
);

  state_e            r_state;
  state_e            w_state_next;
  logic [WORD_W-1:0] r_sreg;
  logic [2:0]        r_bit_idx;
  logic [4:0]        r_words_left;
  logic [3:0]        r_n;
  logic [1:0]        r_mode;
  logic [CNT_W-1:0]  r_hit_cnt;

  logic w_start;
  logic w_capture;
  logic w_strobe;
  logic w_last_bit;
  logic w_hit;

  assign w_start    = (r_state == StIdle) && ctrl.START;
  assign w_capture  = (r_state == StLoad) && ctrl.DIN_VALID;
  assign w_strobe   = (r_state == StShift);
  assign w_last_bit = w_strobe && (r_bit_idx == 3'd7);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (ctrl.START) w_state_next = StLoad;
      StLoad:  if (ctrl.DIN_VALID) w_state_next = StShift;
      StShift: begin
        if (r_bit_idx == 3'd7) begin
          w_state_next = (r_words_left == 5'd0) ? StFin : StLoad;
        end
      end
      StFin:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Configuration latch; WORDS == 0 encodes a 16-word frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_n    <= 4'd0;
      r_mode <= 2'b00;
    end else if (w_start) begin
      r_n    <= clamp_n(ctrl.RUN_LEN);
      r_mode <= ctrl.MODE;
    end
  end

  // Words remaining after the one currently being shifted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_words_left <= 5'd0;
    end else if (w_start) begin
      r_words_left <= (ctrl.WORDS == 4'd0) ? 5'd16 : {1'b0, ctrl.WORDS};
    end else if (w_capture) begin
      r_words_left <= r_words_left - 5'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sreg    <= '0;
      r_bit_idx <= 3'd0;
    end else if (w_start) begin
      r_sreg    <= '0;
      r_bit_idx <= 3'd0;
    end else if (w_capture) begin
      r_sreg    <= ctrl.DIN;
      r_bit_idx <= 3'd0;
    end else if (w_strobe) begin
      r_sreg    <= {r_sreg[WORD_W-2:0], 1'b0};
      r_bit_idx <= r_bit_idx + 3'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hit_cnt <= '0;
    end else if (w_start) begin
      r_hit_cnt <= '0;
    end else if (w_hit && (r_hit_cnt != {CNT_W{1'b1}})) begin
      r_hit_cnt <= r_hit_cnt + 1'b1;
    end
  end

  run_detector u_run_detector (
    .CLK      (CLK),
    .RST      (RST),
    .i_bit    (r_sreg[WORD_W-1]),
    .i_strobe (w_strobe),
    .i_clear  (w_start),
    .i_n      (r_n),
    .i_mode   (r_mode),
    .o_hit    (w_hit)
  );

  assign ctrl.DIN_READY = (r_state == StLoad);
  assign ctrl.BUSY      = (r_state != StIdle);
  assign ctrl.DONE      = (r_state == StFin);
  assign ctrl.HIT       = w_hit;
  assign ctrl.HIT_CNT   = r_hit_cnt;

  // r_bit_idx reaching 7 is implied by w_state_next; keep the decode visible.
  logic w_unused;
  assign w_unused = w_last_bit;

endmodule

// File: tb/tb_run_det_ctrl.sv
// Scoreboard bench for run_det_ctrl: frames push expected hit count, hit-bit
// mask and bit count; a monitor rebuilds them from DUT outputs and compares at DONE.
module tb_run_det_ctrl;

  logic CLK;
  logic RST;

  run_det_ctrl_if u_if ();

  run_det_ctrl u_dut (
    .CLK  (CLK),
    .RST  (RST),
    .ctrl (u_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int           cnt;
    logic [127:0] mask;
    int           bits;
    string        name;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: rebuild per-frame hit positions and bit count from DUT outputs.
  initial begin
    int           bits_seen;
    logic [127:0] mask;
    logic         pend;
    exp_t         cur;
    bits_seen = 0;
    mask      = '0;
    pend      = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        bits_seen = 0;
        mask      = '0;
        pend      = 1'b0;
      end else begin
        if (pend) begin
          pend = 1'b0;
          check({cur.name, "_hit_cnt"}, 128'(u_if.HIT_CNT), 128'(cur.cnt));
        end
        if (u_if.HIT) begin
          if (bits_seen >= 1 && bits_seen <= 128) mask[bits_seen-1] = 1'b1;
          else check("hit_outside_frame", 128'(bits_seen), 128'd1);
        end
        if (u_if.BUSY && !u_if.DIN_READY && !u_if.DONE) bits_seen++;
        if (u_if.DONE) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 128'd1, 128'd0);
          end else begin
            cur = sb_q.pop_front();
            check({cur.name, "_hit_mask"}, mask, cur.mask);
            check({cur.name, "_bits"}, 128'(bits_seen), 128'(cur.bits));
            pend = 1'b1;
          end
          bits_seen = 0;
          mask      = '0;
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_frame(input logic [3:0] n, input logic [1:0] mode, input logic [3:0] words);
    step();
    u_if.START   = 1'b1;
    u_if.RUN_LEN = n;
    u_if.MODE    = mode;
    u_if.WORDS   = words;
    step();
    u_if.START   = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d, input int stall);
    int t;
    t = 0;
    while (!u_if.DIN_READY && t < 100) begin
      step();
      t++;
    end
    if (!u_if.DIN_READY) check("ready_timeout", 128'd0, 128'd1);
    for (int i = 0; i < stall; i++) begin
      check("stall_ready", 128'(u_if.DIN_READY), 128'd1);
      check("stall_busy", 128'(u_if.BUSY), 128'd1);
      step();
    end
    u_if.DIN       = d;
    u_if.DIN_VALID = 1'b1;
    step();
    u_if.DIN_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (u_if.BUSY && t < 300) begin
      step();
      t++;
    end
    if (u_if.BUSY) check("idle_timeout", 128'd1, 128'd0);
    step();
    step();
  endtask

  task automatic run_frame(input logic [3:0] n, input logic [1:0] mode, input logic [3:0] words,
                           input logic [7:0] d0, input logic [7:0] d1, input int nsend,
                           input int stall, input int exp_cnt, input logic [127:0] exp_mask,
                           input string name);
    exp_t e;
    e.cnt  = exp_cnt;
    e.mask = exp_mask;
    e.bits = nsend * 8;
    e.name = name;
    sb_q.push_back(e);
    start_frame(n, mode, words);
    for (int i = 0; i < nsend; i++) send_word((i == 0) ? d0 : d1, (i == 0) ? stall : 0);
    wait_idle();
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ready"}, 128'(u_if.DIN_READY), 128'd0);
    check({name, "_hit"}, 128'(u_if.HIT), 128'd0);
    check({name, "_hit_cnt"}, 128'(u_if.HIT_CNT), 128'd0);
    check({name, "_busy"}, 128'(u_if.BUSY), 128'd0);
    check({name, "_done"}, 128'(u_if.DONE), 128'd0);
  endtask

  initial begin
    RST            = 1'b0;
    u_if.START     = 1'b0;
    u_if.RUN_LEN   = 4'd0;
    u_if.MODE      = 2'b00;
    u_if.WORDS     = 4'd0;
    u_if.DIN       = 8'h00;
    u_if.DIN_VALID = 1'b0;
    repeat (3) step();
    check_outputs_zero("reset");
    RST = 1'b1;
    step();

    // DIN_VALID in IDLE must be neither accepted nor start anything.
    u_if.DIN_VALID = 1'b1;
    u_if.DIN       = 8'hAA;
    step();
    check("idle_ready_low", 128'(u_if.DIN_READY), 128'd0);
    check("idle_busy_low", 128'(u_if.BUSY), 128'd0);
    u_if.DIN_VALID = 1'b0;

    run_frame(4'd4, 2'b00, 4'd1, 8'h0F, 8'h00, 1, 0, 1, 128'h08, "n4_zero_0f");
    run_frame(4'd4, 2'b10, 4'd1, 8'h0F, 8'h00, 1, 0, 2, 128'h88, "n4_any_0f");
    run_frame(4'd6, 2'b00, 4'd2, 8'hF0, 8'h3F, 2, 0, 1, 128'h200, "n6_cross_word");
    run_frame(4'd4, 2'b00, 4'd1, 8'h00, 8'h00, 1, 0, 5, 128'hF8, "n4_overlap_00");
    run_frame(4'd4, 2'b00, 4'd1, 8'h0F, 8'h00, 1, 3, 1, 128'h08, "stall_0f");
    run_frame(4'd1, 2'b01, 4'd1, 8'hFF, 8'h00, 1, 0, 7, 128'hFE, "n1_clamp");
    run_frame(4'd15, 2'b01, 4'd1, 8'hFF, 8'h00, 1, 0, 1, 128'h80, "n15_clamp");
    run_frame(4'd2, 2'b11, 4'd0, 8'h55, 8'h55, 16, 0, 0, 128'h0, "words16_alt");

    // Abort mid-frame: no DONE may follow, outputs clear at once.
    start_frame(4'd4, 2'b00, 4'd2);
    send_word(8'hF0, 0);
    repeat (3) step();
    RST = 1'b0;
    #1;
    check_outputs_zero("mid_rst");
    repeat (2) step();
    check_outputs_zero("mid_rst_hold");
    RST = 1'b1;
    repeat (20) step();
    check("mid_rst_no_restart", 128'(u_if.BUSY), 128'd0);
    run_frame(4'd8, 2'b01, 4'd1, 8'hFF, 8'h00, 1, 0, 1, 128'h80, "rst_recover");

    repeat (4) step();
    check("scoreboard_drained", 128'(sb_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
